rgmii_rx_framer: RTL
====================

// Module: rgmii_rx_framer
// PURPOSE
//  Receive-side GMII framer behind the RGMII input DDR stage, in the 125 MHz RX clock domain.
//  Takes decoded per-cycle byte/dv/er and strips preamble/SFD.
//  Emits each frame as a valid/last/user byte stream with no backpressure, at line rate.
//  Decodes in-band link status between frames and keeps good/bad frame counters.
// PARAMETERS
//  MIN_LEN   64    min bytes after SFD (incl. FCS); shorter frame -> tuser=1 on tlast
//  MAX_LEN   1522  max bytes after SFD; reaching it truncates the frame (see BEHAVIOUR)
//  CNT_W     16    width of frame_cnt / err_cnt
// PORTS
//  clk            in   1      RX clock, 125 MHz, one clock domain
//  rst_n          in   1      asynchronous, active-low reset
//  gmii_rxd       in   8      received byte
//  gmii_rx_dv     in   1      data valid
//  gmii_rx_er     in   1      receive error
//  m_tdata        out  8      frame byte (first byte after SFD onward, FCS included)
//  m_tvalid       out  1      byte valid; no tready, consumer must always accept
//  m_tlast        out  1      last byte of frame
//  m_tuser        out  1      frame error; meaningful only with m_tlast
//  link_up        out  1      in-band status rxd[0]
//  link_speed     out  2      in-band rxd[2:1]: 00=10M 01=100M 10=1G
//  link_duplex    out  1      in-band rxd[3]: 1=full
//  frame_cnt      out  CNT_W  frames ended with tuser=0; wraps
//  err_cnt        out  CNT_W  frames ended with tuser=1, plus empty frames; wraps
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, hold register empty.
//  FSM (registered, rxd/dv/er sampled on rising clk):
//   IDLE:  dv=0,er=0 -> latch in-band status from rxd[3:0] into link_*.
//          dv=1 and rxd=55h -> PRE.  dv=1 and rxd=D5h -> DATA (short preamble legal).
//          dv=1 and any other rxd -> DROP.
//   PRE:   rxd=55h stay.  rxd=D5h -> DATA.  dv=0 -> IDLE, no output.  Other byte -> DROP.
//   DATA:  each dv=1 byte is loaded into a 1-byte hold register.
//          The previous held byte is emitted with tvalid=1, tlast=0.
//          dv=0 -> emit held byte with tlast=1, go to IDLE.
//          dv fall right after SFD (0 bytes) -> no output, err_cnt++, IDLE.
//   DROP:  no output; stay until dv=0, then IDLE. Not counted.
//  Latency: rxd byte appears on m_tdata exactly 1 clk after its sample, at line rate.
//  Error flag (sticky per frame, cleared on SFD), set by any of:
//   - er=1 with dv=1 in DATA
//   - length < MIN_LEN
//   - truncation
//   - CRC fail (if enabled)
//  Truncation: the MAX_LEN-th byte is emitted with tlast=1 and tuser=1; then DROP until dv=0.
//  The byte counter saturates at MAX_LEN.
//  Back-to-back frames: dv low for a single cycle is enough to close one frame and start PRE.
//  The tlast of the old frame and the SFD of the next never collide, since SFD produces no output.
//  Reset mid-frame: outputs drop to 0 asynchronously; a partial frame is never completed.
//  Counters update in the cycle after tlast.
// CONFIGURATION
//  RGMII_RX_CRC_CHECK_EN defined:
//   - Running reflected CRC-32 (poly 04C11DB7, init FFFFFFFFh) over all bytes after SFD.
//   - At frame end, a residue other than C704DD7Bh sets tuser on tlast.
//  Undefined:
//   - No CRC logic; tuser reflects er/length/truncation only.
//  Stream timing is identical either way.
// STRUCTURE
//  Package rgmii_pkg: state enum {IDLE,PRE,DATA,DROP}; PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
//   CRC_POLY, CRC_INIT, CRC_RESIDUE; speed code constants.
//  Sub-module rgmii_crc32_d8: combinational next-CRC for one byte (crc_in[31:0], d[7:0] -> crc_out).
//   Instantiated only under RGMII_RX_CRC_CHECK_EN.
// TESTING
//  1 Frame: 7x55h, D5h, 60 payload bytes + valid FCS (64 B) -> 64 beats 1 clk late,
//    tlast on 64th, tuser=0, frame_cnt=1.
//  2 Same frame with er=1 on byte 10 -> all 64 bytes delivered, tuser=1, err_cnt=1, frame_cnt unchanged.
//  3 Frame of 40 B after SFD -> tlast on byte 40, tuser=1 (runt).
//    Next frame after a 1-cycle dv gap is delivered cleanly.
//  4 2000 B after SFD -> tlast+tuser on byte 1522, nothing more until dv=0, err_cnt++.
//  5 Idle with rxd=0Dh, dv=0 -> link_up=1, link_speed=10b, link_duplex=1.
//    Preamble 55,55,AAh -> DROP, no output.
//  6 rst_n asserted mid-payload -> tvalid=0 immediately.
//    After release, the next full frame passes correctly.
//    With CRC_EN: corrupted FCS byte -> tuser=1.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive framer.
// Optional CRC checking is enabled with RGMII_RX_CRC_CHECK_EN.
package rgmii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  localparam logic [1:0]  SPEED_10M     = 2'b00;
  localparam logic [1:0]  SPEED_100M    = 2'b01;
  localparam logic [1:0]  SPEED_1G      = 2'b10;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/rgmii_crc32_d8.sv
// Combinational one-byte step of the reflected (LSB-first) Ethernet CRC-32.
// Only instantiated when RGMII_RX_CRC_CHECK_EN is defined.
module rgmii_crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = bit_rev32(CRC_POLY);

  always_comb begin
    crc_out = crc_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/rgmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, emits a valid/last/user byte stream,
// latches in-band link status and counts frames. CRC check under RGMII_RX_CRC_CHECK_EN.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int              LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic             empty_q, empty_d;
  logic             link_up_q, link_up_d, link_duplex_q, link_duplex_d;
  logic [1:0]       link_speed_q, link_speed_d;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
  logic             sfd_hit, load_byte, crc_bad;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    len_d         = len_q;
    err_d         = err_q;
    tdata_d       = tdata_q;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;
    tuser_d       = 1'b0;
    empty_d       = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    link_duplex_d = link_duplex_q;
    sfd_hit       = 1'b0;
    load_byte     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!gmii_rx_dv && !gmii_rx_er) begin
          link_up_d     = gmii_rxd[0];
          link_speed_d  = gmii_rxd[2:1];
          link_duplex_d = gmii_rxd[3];
        end else if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) state_d = PRE;
          else if (gmii_rxd == SFD_BYTE) begin
            state_d = DATA;
            sfd_hit = 1'b1;
          end else state_d = DROP;
        end
      end
      PRE: begin
        if (!gmii_rx_dv) state_d = IDLE;
        else if (gmii_rxd == SFD_BYTE) begin
          state_d = DATA;
          sfd_hit = 1'b1;
        end else if (gmii_rxd != PREAMBLE_BYTE) state_d = DROP;
      end
      DATA: begin
        // Hold register delays the stream one byte so tlast can ride on the final byte.
        if (len_q == MAX_L) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tuser_d  = 1'b1;
          tdata_d  = hold_q;
          state_d  = gmii_rx_dv ? DROP : IDLE;
        end else if (gmii_rx_dv) begin
          if (len_q != '0) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
          end
          hold_d    = gmii_rxd;
          len_d     = len_q + LEN_W'(1);
          load_byte = 1'b1;
          if (gmii_rx_er) err_d = 1'b1;
        end else begin
          state_d = IDLE;
          if (len_q == '0) empty_d = 1'b1;
          else begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = hold_q;
            tuser_d  = err_q || (len_q < MIN_L) || crc_bad;
          end
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sfd_hit) begin
      len_d = '0;
      err_d = 1'b0;
    end
  end

`ifdef RGMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  rgmii_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (gmii_rxd),
    .crc_out (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    if (sfd_hit)        crc_d = CRC_INIT;
    else if (load_byte) crc_d = crc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  // Register is LSB-first; the residue constant is in MSB-first notation.
  assign crc_bad = (bit_rev32(crc_q) != CRC_RESIDUE);
`else
  logic unused_crc_load;
  assign unused_crc_load = load_byte;
  assign crc_bad         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      empty_q       <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= SPEED_10M;
      link_duplex_q <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      len_q         <= len_d;
      err_q         <= err_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      empty_q       <= empty_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      link_duplex_q <= link_duplex_d;
      if (tlast_q && !tuser_q)              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if ((tlast_q && tuser_q) || empty_q)  err_cnt_q   <= err_cnt_q + CNT_W'(1);
    end
  end

  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign m_tuser     = tuser_q;
  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign link_duplex = link_duplex_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
